uart_tx_fifo_sched: RTL and testbench
=====================================

// Module: uart_tx_fifo_sched
// PURPOSE
//  Shares one UART TX FIFO between two byte-stream producers (sensor 0, sensor 1) and drains it into the UART transmitter.
//  Arbitration is round-robin at packet granularity, so one producer's bytes are never interleaved with the other's.
//  Push side drives the FIFO controller's push/full pair; pop side drives pop/empty and sequences tx start/busy.
// PARAMETERS
//  MAX_PKT_LEN   16   bytes accepted from one owner before the grant is force-released (range 1..255)
// PORTS
//  iClk          in   1  system clock
//  iRst          in   1  asynchronous, active-high reset
//  iReq0_Valid   in   1  producer 0 byte valid
//  iReq0_Data    in   8  producer 0 byte
//  iReq0_Last    in   1  producer 0 last byte of packet
//  oReq0_Ready   out  1  producer 0 byte accepted this cycle when Valid&Ready
//  iReq1_Valid   in   1  producer 1 byte valid
//  iReq1_Data    in   8  producer 1 byte
//  iReq1_Last    in   1  producer 1 last byte of packet
//  oReq1_Ready   out  1  producer 1 ready
//  oGrant        out  2  one-hot current owner ({1,0}); 2'b00 = no owner
//  oPush         out  1  FIFO push strobe
//  oWrData       out  8  FIFO write data
//  iFull         in   1  FIFO full
//  oPop          out  1  FIFO pop strobe (1-cycle pulse)
//  iRdData       in   8  FIFO head byte; valid whenever iEmpty=0 (show-ahead)
//  iEmpty        in   1  FIFO empty
//  oTxStart      out  1  UART TX start pulse (1 cycle)
//  oTxData       out  8  UART TX byte, held stable from start until busy falls
//  iTxBusy       in   1  UART TX busy
// BEHAVIOUR
//  Reset: oGrant=00, oReqN_Ready=0, oPush=0, oPop=0, oTxStart=0, oTxData=0, byte count=0;
//   last-granted pointer=1, so producer 0 wins the first contention. Reset mid-packet drops ownership; no byte is pushed that cycle.
//  Arbiter FSM ARB_IDLE / ARB_OWN0 / ARB_OWN1 (registered):
//   ARB_IDLE: if exactly one Valid, grant it; if both valid, grant the one not granted last; if none, stay.
//    Grant takes effect next cycle (Valid->Ready latency 1 cycle min).
//   ARB_OWNn: oReqn_Ready = !iFull (combinational); the other producer's Ready=0.
//    Accepted byte (Valid&Ready): oPush=1, oWrData=iReqn_Data same cycle; count+1.
//    Accepted byte with Last=1, or count reaching MAX_PKT_LEN: next state ARB_IDLE, count=0, last-granted=n.
//    Owner Valid=0 mid-packet: keep grant (no timeout); iFull=1: Ready=0, no push, hold state.
//  oPush = Valid&Ready of owner only; never asserted in ARB_IDLE; never asserted while iFull=1.
//  Drain FSM DR_IDLE / DR_START / DR_BUSY / DR_WAIT:
//   DR_IDLE: if !iEmpty & !iTxBusy: latch oTxData<=iRdData, oPop=1 (this cycle only), -> DR_START.
//   DR_START: oTxStart=1 for one cycle -> DR_BUSY.
//   DR_BUSY: wait for iTxBusy=1 -> DR_WAIT.
//   DR_WAIT: wait for iTxBusy=0 -> DR_IDLE.
//   Per byte: at most one pop; pop-to-start latency 1 cycle; next pop no earlier than the cycle after busy falls.
//  Push and pop in the same cycle are independent and both issued; the FIFO resolves them (full/empty flags update next cycle).
//  iEmpty=1 in DR_IDLE: no pop; a pop is never issued while iEmpty=1.
//  Byte count is 8-bit, saturates at MAX_PKT_LEN and never wraps.
// TESTING
//  T1 P0 sends 3-byte packet 41,42,43(Last), P1 idle -> grant 01 one cycle after Valid; pushes 41,42,43 on consecutive cycles; then ARB_IDLE.
//  T2 Both Valid from reset with packets {A0,A1} and {B0,B1} -> FIFO order A0,A1,B0,B1; next contention grants P0 again after P1.
//  T3 FIFO full mid-packet (iFull=1 for 5 cycles) -> owner Ready=0, no push for 5 cycles; resume with no byte lost or duplicated.
//  T4 P1 streams 20 bytes with Last never set, MAX_PKT_LEN=16 -> grant released after byte 16; P0 (valid) granted next; P1 continues after P0's packet.
//  T5 FIFO holds 55,AA with iTxBusy modelled as 10 cycles after start -> oPop/oTxStart pairs 1 cycle apart; oTxData 55 then AA, held through busy.
//  T6 Assert iRst during ARB_OWN0 and DR_BUSY -> all outputs 0 next edge; FSMs IDLE; first post-reset contention grants P0.

Source files
------------

// File: rtl/uart_tx_fifo_sched_if.sv
// Producer, FIFO and UART signal bundle for uart_tx_fifo_sched.
// slave: scheduler side; master: environment side (producers, FIFO, UART).
interface uart_tx_fifo_sched_if;
  logic       iReq0_Valid;
  logic [7:0] iReq0_Data;
  logic       iReq0_Last;
  logic       oReq0_Ready;
  logic       iReq1_Valid;
  logic [7:0] iReq1_Data;
  logic       iReq1_Last;
  logic       oReq1_Ready;
  logic [1:0] oGrant;
  logic       oPush;
  logic [7:0] oWrData;
  logic       iFull;
  logic       oPop;
  logic [7:0] iRdData;
  logic       iEmpty;
  logic       oTxStart;
  logic [7:0] oTxData;
  logic       iTxBusy;

  modport slave (
    input  iReq0_Valid, iReq0_Data, iReq0_Last,
    input  iReq1_Valid, iReq1_Data, iReq1_Last,
    input  iFull, iRdData, iEmpty, iTxBusy,
    output oReq0_Ready, oReq1_Ready, oGrant,
    output oPush, oWrData, oPop,
    output oTxStart, oTxData
  );

  modport master (
    output iReq0_Valid, iReq0_Data, iReq0_Last,
    output iReq1_Valid, iReq1_Data, iReq1_Last,
    output iFull, iRdData, iEmpty, iTxBusy,
    input  oReq0_Ready, oReq1_Ready, oGrant,
    input  oPush, oWrData, oPop,
    input  oTxStart, oTxData
  );
endinterface

// File: rtl/uart_tx_fifo_sched.sv
// Two-producer packet round-robin into a shared UART TX FIFO, plus drain.
// Ports: iClk, iRst (async, active-high), bus (slave modport).
module uart_tx_fifo_sched #(
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic iClk,
  input  logic iRst,
  uart_tx_fifo_sched_if.slave bus
);

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_OWN0 = 2'd1;
  localparam logic [1:0] ARB_OWN1 = 2'd2;

  localparam logic [1:0] DR_IDLE  = 2'd0;
  localparam logic [1:0] DR_START = 2'd1;
  localparam logic [1:0] DR_BUSY  = 2'd2;
  localparam logic [1:0] DR_WAIT  = 2'd3;

  localparam logic [7:0] MaxLen = 8'(MAX_PKT_LEN);

  logic [1:0] arb_q, arb_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] dr_q, dr_d;
  logic [7:0] txd_q, txd_d;

  logic       own0, own1;
  logic       acc, acc_last;
  logic [7:0] cnt_inc;
  logic       pop;

  assign own0 = (arb_q == ARB_OWN0);
  assign own1 = (arb_q == ARB_OWN1);

  assign bus.oGrant      = {own1, own0};
  assign bus.oReq0_Ready = own0 & ~bus.iFull;
  assign bus.oReq1_Ready = own1 & ~bus.iFull;

  assign acc = ~bus.iFull &
               ((own0 & bus.iReq0_Valid) |
                (own1 & bus.iReq1_Valid));
  assign acc_last = own1 ? bus.iReq1_Last
                         : bus.iReq0_Last;

  assign bus.oPush   = acc;
  assign bus.oWrData = own1 ? bus.iReq1_Data :
                       own0 ? bus.iReq0_Data :
                              8'h00;

  // Saturating so a long owner can never wrap the count.
  assign cnt_inc = (cnt_q >= MaxLen) ? cnt_q
                                     : cnt_q + 8'd1;

  always_comb begin
    arb_d  = arb_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    unique case (arb_q)
      ARB_IDLE: begin
        if (bus.iReq0_Valid & bus.iReq1_Valid)
          arb_d = last_q ? ARB_OWN0 : ARB_OWN1;
        else if (bus.iReq0_Valid)
          arb_d = ARB_OWN0;
        else if (bus.iReq1_Valid)
          arb_d = ARB_OWN1;
      end
      ARB_OWN0, ARB_OWN1: begin
        if (acc) begin
          cnt_d = cnt_inc;
          if (acc_last || cnt_inc == MaxLen) begin
            arb_d  = ARB_IDLE;
            cnt_d  = 8'd0;
            last_d = own1;
          end
        end
      end
      default: arb_d = ARB_IDLE;
    endcase
  end

  // Pop is combinational off the idle state; reset masks it so a
  // non-empty FIFO is never popped while the block is held in reset.
  assign pop = ~iRst & (dr_q == DR_IDLE) &
               ~bus.iEmpty & ~bus.iTxBusy;

  assign bus.oPop     = pop;
  assign bus.oTxStart = (dr_q == DR_START);
  assign bus.oTxData  = txd_q;

  always_comb begin
    dr_d  = dr_q;
    txd_d = txd_q;
    unique case (dr_q)
      DR_IDLE: begin
        if (pop) begin
          txd_d = bus.iRdData;
          dr_d  = DR_START;
        end
      end
      DR_START: dr_d = DR_BUSY;
      DR_BUSY:  if (bus.iTxBusy) dr_d = DR_WAIT;
      DR_WAIT:  if (!bus.iTxBusy) dr_d = DR_IDLE;
      default:  dr_d = DR_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      arb_q  <= ARB_IDLE;
      last_q <= 1'b1;
      cnt_q  <= 8'd0;
      dr_q   <= DR_IDLE;
      txd_q  <= 8'd0;
    end else begin
      arb_q  <= arb_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      dr_q   <= dr_d;
      txd_q  <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// Randomised, model-checked bench for uart_tx_fifo_sched.
// Models the FIFO and UART; expected order comes from a packet model.
module tb_uart_tx_fifo_sched;

  typedef logic [8:0] bq_t[$];
  typedef logic [7:0] b8q_t[$];

  localparam int MAXP = 16;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  always #5 iClk = ~iClk;

  uart_tx_fifo_sched_if bus();

  uart_tx_fifo_sched #(.MAX_PKT_LEN(MAXP)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (bus)
  );

  int npass = 0;
  int ntot  = 0;

  bq_t  p0q, p1q;
  bit   en0 = 0, en1 = 0;
  b8q_t fq;
  int   fdepth = 64;
  logic force_full = 1'b0;
  logic full_q = 1'b0;

  b8q_t plog, ulog;
  int   pcyc[$], popcyc[$], scyc[$], fallcyc[$];
  int   cyc = 0;
  int   bcnt = 0;
  logic [7:0] tx_cur = 8'h00;
  int   hold_err = 0;
  int   v0_first = -1;
  int   g0_first = -1;

  assign bus.iFull = force_full | full_q;

  // Producer drivers: present queue head on the falling edge.
  always @(negedge iClk) begin
    bus.iReq0_Valid = en0 && p0q.size() > 0;
    bus.iReq0_Data  = p0q.size() > 0 ? p0q[0][7:0] : 8'h00;
    bus.iReq0_Last  = p0q.size() > 0 ? p0q[0][8]   : 1'b0;
    bus.iReq1_Valid = en1 && p1q.size() > 0;
    bus.iReq1_Data  = p1q.size() > 0 ? p1q[0][7:0] : 8'h00;
    bus.iReq1_Last  = p1q.size() > 0 ? p1q[0][8]   : 1'b0;
  end

  // FIFO, UART and handshake observation on the rising edge.
  always @(posedge iClk) begin
    cyc++;
    if (iRst) begin
      fq.delete();
      bcnt = 0;
    end else begin
      if (bus.iReq0_Valid && bus.oReq0_Ready)
        void'(p0q.pop_front());
      if (bus.iReq1_Valid && bus.oReq1_Ready)
        void'(p1q.pop_front());
      if (v0_first < 0 && bus.iReq0_Valid)
        v0_first = cyc;
      if (g0_first < 0 && bus.oGrant == 2'b01)
        g0_first = cyc;
      if (bus.oPush) begin
        fq.push_back(bus.oWrData);
        plog.push_back(bus.oWrData);
        pcyc.push_back(cyc);
      end
      if (bus.oPop && fq.size() > 0) begin
        void'(fq.pop_front());
        popcyc.push_back(cyc);
      end
      if (bus.iTxBusy && bus.oTxData !== tx_cur)
        hold_err++;
      if (bus.oTxStart) begin
        ulog.push_back(bus.oTxData);
        scyc.push_back(cyc);
        tx_cur = bus.oTxData;
        bcnt = 10;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) fallcyc.push_back(cyc);
      end
    end
    full_q      <= fq.size() >= fdepth;
    bus.iEmpty  <= fq.size() == 0;
    bus.iRdData <= fq.size() > 0 ? fq[0] : 8'h00;
    bus.iTxBusy <= bcnt > 0;
  end

  // Packet-level round robin: segments end on Last or MAXP bytes,
  // owners alternate while both have data.
  function automatic void ref_order(
    input bq_t a, input bq_t b,
    input int first, output b8q_t o);
    int turn;
    int n;
    logic [8:0] x;
    o = {};
    turn = first;
    while (a.size() > 0 || b.size() > 0) begin
      if (turn == 0 && a.size() == 0) turn = 1;
      else if (turn == 1 && b.size() == 0) turn = 0;
      n = 0;
      do begin
        if (turn == 0) x = a.pop_front();
        else x = b.pop_front();
        o.push_back(x[7:0]);
        n++;
      end while (!x[8] && n < MAXP &&
                 (turn == 0 ? a.size() : b.size()) > 0);
      turn = 1 - turn;
    end
  endfunction

  function automatic int first_diff(
    input b8q_t a, input b8q_t b);
    int n;
    n = a.size() < b.size() ? a.size() : b.size();
    for (int i = 0; i < n; i++)
      if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic bq_t mk_pkt(input int len, input bit last);
    bq_t q;
    q = {};
    for (int i = 0; i < len; i++)
      q.push_back({last && i == len - 1,
                   8'($urandom_range(0, 255))});
    return q;
  endfunction

  task automatic clear_logs;
    plog.delete(); ulog.delete();
    pcyc.delete(); popcyc.delete();
    scyc.delete(); fallcyc.delete();
    hold_err = 0;
    v0_first = -1;
    g0_first = -1;
  endtask

  task automatic apply_reset;
    @(negedge iClk);
    iRst = 1'b1;
    en0 = 0; en1 = 0;
    p0q.delete(); p1q.delete();
    force_full = 1'b0;
    fdepth = 64;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int q;
    q = 0;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge iClk);
      if (p0q.size() == 0 && p1q.size() == 0 &&
          fq.size() == 0 && bcnt == 0 &&
          !bus.oTxStart && !bus.iTxBusy) q++;
      else q = 0;
      if (q >= 4) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    apply_reset();
    #1;
    ntot++;
    if (bus.oGrant !== 2'b00)
      $display("FAIL reset_grant: got %b want 00", bus.oGrant);
    else npass++;
    ntot++;
    if ({bus.oReq0_Ready, bus.oReq1_Ready} !== 2'b00)
      $display("FAIL reset_ready: got %b want 00",
               {bus.oReq0_Ready, bus.oReq1_Ready});
    else npass++;
    ntot++;
    if ({bus.oPush, bus.oPop, bus.oTxStart} !== 3'b000)
      $display("FAIL reset_strobes: got %b want 000",
               {bus.oPush, bus.oPop, bus.oTxStart});
    else npass++;
    ntot++;
    if (bus.oTxData !== 8'h00)
      $display("FAIL reset_txdata: got %h want 00", bus.oTxData);
    else npass++;
  endtask

  task automatic test_single;
    bq_t a, b;
    b8q_t exp;
    bit ok, cons;
    int d;
    apply_reset();
    a = {9'h041, 9'h042, 9'h143};
    b = {};
    ref_order(a, b, 0, exp);
    p0q = a;
    en0 = 1;
    wait_done(300, ok);
    ntot++;
    if (!ok) $display("FAIL single_timeout: done=0 want 1");
    else npass++;
    d = first_diff(plog, exp);
    ntot++;
    if (d >= 0)
      $display("FAIL single_order: idx %0d got n=%0d want n=%0d",
               d, plog.size(), exp.size());
    else npass++;
    ntot++;
    if (g0_first !== v0_first + 1)
      $display("FAIL single_grant_lat: got %0d want %0d",
               g0_first - v0_first, 1);
    else npass++;
    cons = pcyc.size() == 3;
    for (int i = 1; i < pcyc.size(); i++)
      if (pcyc[i] != pcyc[0] + i) cons = 0;
    ntot++;
    if (!cons || pcyc[0] != v0_first + 1)
      $display("FAIL single_push_cycles: got first=%0d want %0d",
               pcyc.size() > 0 ? pcyc[0] : -1, v0_first + 1);
    else npass++;
    ntot++;
    if (bus.oGrant !== 2'b00)
      $display("FAIL single_idle: got %b want 00", bus.oGrant);
    else npass++;
  endtask

  task automatic test_contention;
    bq_t a, b;
    b8q_t exp, exp2;
    bit ok;
    int d;
    apply_reset();
    a = {9'h0A0, 9'h1A1};
    b = {9'h0B0, 9'h1B1};
    ref_order(a, b, 0, exp);
    p0q = a; p1q = b;
    en0 = 1; en1 = 1;
    wait_done(300, ok);
    d = first_diff(plog, exp);
    ntot++;
    if (!ok || d >= 0)
      $display("FAIL contend_order: ok=%0d idx %0d got n=%0d want n=%0d",
               ok, d, plog.size(), exp.size());
    else npass++;
    plog.delete();
    a = {9'h1C0};
    b = {9'h1D0};
    ref_order(a, b, 0, exp2);
    p0q = a; p1q = b;
    wait_done(300, ok);
    d = first_diff(plog, exp2);
    ntot++;
    if (!ok || d >= 0)
      $display("FAIL contend_again: got %h want %h",
               plog.size() > 0 ? plog[0] : 8'hxx, exp2[0]);
    else npass++;
    exp = {exp, exp2};
    d = first_diff(ulog, exp);
    ntot++;
    if (d >= 0)
      $display("FAIL contend_uart: idx %0d got n=%0d want n=%0d",
               d, ulog.size(), exp.size());
    else npass++;
  endtask

  task automatic test_full_stall;
    bq_t a, b;
    b8q_t exp;
    bit ok;
    int d, n0, viol, t;
    apply_reset();
    a = mk_pkt(8, 1);
    b = {};
    ref_order(a, b, 0, exp);
    p0q = a;
    en0 = 1;
    t = 0;
    while (plog.size() < 2 && t < 100) begin
      @(negedge iClk);
      t++;
    end
    ntot++;
    if (plog.size() < 2)
      $display("FAIL full_setup: got %0d pushes want 2", plog.size());
    else npass++;
    force_full = 1'b1;
    n0 = plog.size();
    viol = 0;
    repeat (5) begin
      #1;
      if (bus.oPush !== 1'b0 || bus.oReq0_Ready !== 1'b0 ||
          bus.oGrant !== 2'b01) viol++;
      @(negedge iClk);
    end
    force_full = 1'b0;
    ntot++;
    if (viol != 0 || plog.size() != n0)
      $display("FAIL full_hold: got %0d bad cycles, %0d pushes want 0",
               viol, plog.size() - n0);
    else npass++;
    wait_done(400, ok);
    d = first_diff(plog, exp);
    ntot++;
    if (!ok || d >= 0)
      $display("FAIL full_resume: idx %0d got n=%0d want n=%0d",
               d, plog.size(), exp.size());
    else npass++;
  endtask

  task automatic test_max_len;
    bq_t a, b;
    b8q_t exp;
    bit ok;
    int d, t;
    apply_reset();
    b = mk_pkt(20, 0);
    a = mk_pkt(2, 1);
    ref_order(a, b, 1, exp);
    p1q = b;
    en1 = 1;
    t = 0;
    while (plog.size() < 3 && t < 100) begin
      @(negedge iClk);
      t++;
    end
    p0q = a;
    en0 = 1;
    wait_done(600, ok);
    d = first_diff(plog, exp);
    ntot++;
    if (!ok || d >= 0)
      $display("FAIL maxlen_order: idx %0d got n=%0d want n=%0d",
               d, plog.size(), exp.size());
    else npass++;
    ntot++;
    if (pcyc.size() < 17 || pcyc[16] - pcyc[15] < 2)
      $display("FAIL maxlen_release: got gap %0d want >=2",
               pcyc.size() < 17 ? -1 : pcyc[16] - pcyc[15]);
    else npass++;
    ntot++;
    if (bus.oGrant !== 2'b10)
      $display("FAIL maxlen_hold: got %b want 10", bus.oGrant);
    else npass++;
  endtask

  task automatic test_drain;
    b8q_t exp;
    bit ok, lat;
    int d;
    apply_reset();
    @(negedge iClk);
    fq.push_back(8'h55);
    fq.push_back(8'hAA);
    exp = {8'h55, 8'hAA};
    wait_done(300, ok);
    ntot++;
    if (!ok || popcyc.size() != 2 || scyc.size() != 2)
      $display("FAIL drain_count: got pops=%0d starts=%0d want 2",
               popcyc.size(), scyc.size());
    else npass++;
    lat = popcyc.size() == 2 && scyc.size() == 2;
    for (int i = 0; i < 2 && lat; i++)
      if (scyc[i] != popcyc[i] + 1) lat = 0;
    ntot++;
    if (!lat)
      $display("FAIL drain_latency: got start-pop mismatch want 1");
    else npass++;
    d = first_diff(ulog, exp);
    ntot++;
    if (d >= 0)
      $display("FAIL drain_data: got %h want %h",
               ulog.size() > d ? ulog[d] : 8'hxx, exp[d]);
    else npass++;
    ntot++;
    if (hold_err != 0)
      $display("FAIL drain_hold: got %0d changes want 0", hold_err);
    else npass++;
    ntot++;
    if (popcyc.size() < 2 || fallcyc.size() < 1 ||
        popcyc[1] <= fallcyc[0])
      $display("FAIL drain_spacing: got pop2=%0d want >%0d",
               popcyc.size() > 1 ? popcyc[1] : -1,
               fallcyc.size() > 0 ? fallcyc[0] : -1);
    else npass++;
  endtask

  task automatic test_reset_mid;
    bq_t a, b;
    b8q_t exp;
    bit ok, seen;
    int d;
    logic [15:0] outs;
    apply_reset();
    p0q = mk_pkt(10, 1);
    @(negedge iClk);
    fq.push_back(8'h77);
    en0 = 1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge iClk);
      if (bus.oTxStart) seen = 1;
    end
    @(negedge iClk);
    ntot++;
    if (!seen || bus.oGrant !== 2'b01)
      $display("FAIL rstmid_setup: got start=%0d grant=%b want 1,01",
               seen, bus.oGrant);
    else npass++;
    iRst = 1'b1;
    en0 = 0;
    p0q.delete();
    #1;
    outs = {bus.oGrant, bus.oReq0_Ready, bus.oReq1_Ready,
            bus.oPush, bus.oPop, bus.oTxStart, 1'b0, bus.oTxData};
    ntot++;
    if (outs !== 16'h0000)
      $display("FAIL rstmid_outputs: got %h want 0000", outs);
    else npass++;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    clear_logs();
    a = {9'h1E0};
    b = {9'h1F0};
    ref_order(a, b, 0, exp);
    p0q = a; p1q = b;
    en0 = 1; en1 = 1;
    wait_done(300, ok);
    d = first_diff(plog, exp);
    ntot++;
    if (!ok || d >= 0)
      $display("FAIL rstmid_contend: got %h want %h",
               plog.size() > 0 ? plog[0] : 8'hxx, exp[0]);
    else npass++;
    d = first_diff(ulog, exp);
    ntot++;
    if (d >= 0)
      $display("FAIL rstmid_drain: got n=%0d want n=%0d",
               ulog.size(), exp.size());
    else npass++;
  endtask

  task automatic test_random;
    bq_t a, b;
    b8q_t exp;
    bit ok;
    int d;
    apply_reset();
    fdepth = 4;
    a = {}; b = {};
    for (int k = 0; k < 4; k++) begin
      a = {a, mk_pkt($urandom_range(1, 20), 1)};
      b = {b, mk_pkt($urandom_range(1, 20), 1)};
    end
    ref_order(a, b, 0, exp);
    p0q = a; p1q = b;
    en0 = 1; en1 = 1;
    wait_done(20000, ok);
    d = first_diff(plog, exp);
    ntot++;
    if (!ok || d >= 0)
      $display("FAIL random_order: ok=%0d idx %0d got n=%0d want n=%0d",
               ok, d, plog.size(), exp.size());
    else npass++;
    d = first_diff(ulog, exp);
    ntot++;
    if (d >= 0)
      $display("FAIL random_uart: idx %0d got n=%0d want n=%0d",
               d, ulog.size(), exp.size());
    else npass++;
    ntot++;
    if (bus.oGrant !== 2'b00 || hold_err != 0)
      $display("FAIL random_end: got grant=%b holderr=%0d want 00,0",
               bus.oGrant, hold_err);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full_stall();
    test_max_len();
    test_drain();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
